// File: rtl/core_dg_pkg.sv
// Shared types and constants for the 11-bit datagram codeword path.
package core_dg_pkg;

  localparam int DG_W  = 8;
  localparam int CW_W  = 11;
  localparam int SYN_W = 3;

  localparam int P1 = 4;
  localparam int P2 = 5;
  localparam int P4 = 7;

  localparam int D4 = 6;
  localparam int D5 = 8;
  localparam int D6 = 9;
  localparam int D7 = 10;

  typedef struct packed {
    logic [DG_W-1:0]  data;
    logic             corr;
    logic [SYN_W-1:0] syn;
  } dg_entry_t;

  // The Hamming position of a codeword bit is its index minus 3, so a non-zero
  // syndrome names the faulty bit directly once offset back.
  function automatic logic [3:0] syn_to_bit(input logic [SYN_W-1:0] syn);
    return 4'(syn) + 4'd3;
  endfunction

endpackage

// File: rtl/hamming11_dec_comb.sv
// Combinational Hamming(7,4) correction over codeword bits [10:4]; bits [3:0] pass through.
module hamming11_dec_comb
  import core_dg_pkg::*;
(
  input  logic [CW_W-1:0]  cw_i,
  output logic [DG_W-1:0]  data_o,
  output logic             corr_o,
  output logic [SYN_W-1:0] syn_o
);

  logic [SYN_W-1:0] syn;
  logic [CW_W-1:0]  fix;

  always_comb begin
    syn[0] = cw_i[P1] ^ cw_i[D4] ^ cw_i[D5] ^ cw_i[D7];
    syn[1] = cw_i[P2] ^ cw_i[D4] ^ cw_i[D6] ^ cw_i[D7];
    syn[2] = cw_i[P4] ^ cw_i[D5] ^ cw_i[D6] ^ cw_i[D7];

    fix = cw_i;
    if (syn != '0) begin
      fix = cw_i ^ (CW_W'(1) << syn_to_bit(syn));
    end
  end

  assign data_o = {fix[D7], fix[D6], fix[D5], fix[D4], fix[3:0]};
  assign corr_o = (syn != '0);
  assign syn_o  = syn;

endmodule

// File: rtl/core_dg_dec_sync.sv
// Ejection-port datagram decoder: corrects single upper-field errors, buffers two
// results, and counts corrections at accept time.
module core_dg_dec_sync
  import core_dg_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DG_W-1:0]  out_data,
  output logic             out_corr,
  output logic [SYN_W-1:0] out_syn,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_cnt
);

  dg_entry_t        mem_q [DEPTH];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  dg_entry_t        dec;
  dg_entry_t        head;
  logic             push;
  logic             pop;

  hamming11_dec_comb u_dec (
    .cw_i   (in_data),
    .data_o (dec.data),
    .corr_o (dec.corr),
    .syn_o  (dec.syn)
  );

  // Ready comes from registered occupancy only, so there is no valid->ready path.
  assign in_ready  = (occ_q < 2'(DEPTH));
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head      = mem_q[rd_ptr_q];
  assign out_data  = head.data;
  assign out_corr  = head.corr;
  assign out_syn   = head.syn;
  assign err_cnt   = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    cnt_d    = cnt_q;

    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;

    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (push && dec.corr && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      cnt_q    <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= dec;
      end
    end
  end

endmodule

// File: tb/tb_core_dg_dec_sync.sv
// Scoreboard bench for core_dg_dec_sync, built with a 4-bit counter to reach saturation.
module tb_core_dg_dec_sync;
  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [10:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_corr;
  logic [2:0]  out_syn;
  logic        cnt_clr = 1'b0;
  logic [CW-1:0] err_cnt;

  int n_chk = 0;
  int n_err = 0;
  logic [11:0] exp_q [$];
  logic [CW-1:0] cnt_model = '0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  core_dg_dec_sync #(.CNT_W(CW), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_corr(out_corr), .out_syn(out_syn),
    .cnt_clr(cnt_clr), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: a set bit k in 10..4 has Hamming position k-3; the syndrome is the XOR
  // of the positions of all set bits.
  function automatic logic [11:0] model(input logic [10:0] cw);
    logic [2:0]  s = 3'd0;
    logic [10:0] c = cw;
    for (int k = 4; k <= 10; k++) if (cw[k]) s ^= 3'(k - 3);
    if (s != 3'd0) c[int'(s) + 3] = ~c[int'(s) + 3];
    return {c[10], c[9], c[8], c[6], c[3:0], (s != 3'd0), s};
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cnt_model = '0;
    end else begin
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_data));
        if (!cnt_clr && model(in_data)[3:0] != 0 && cnt_model != '1) cnt_model = cnt_model + 1'b1;
      end
      if (cnt_clr) cnt_model = '0;
    end
  end

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("in_ready", in_ready, exp_q.size() < 2);
      chk("out_valid", out_valid, exp_q.size() > 0);
      chk("err_cnt", err_cnt, cnt_model);
      if (out_valid && exp_q.size() > 0) chk("head", {out_data, out_corr, out_syn}, exp_q[0]);
    end
  end

  task automatic send(input logic [10:0] cw);
    int n = 0;
    in_valid = 1'b1;
    in_data  = cw;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("send_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    logic [10:0] cw;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", {out_data, out_corr, out_syn}, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(posedge clk); #1;
    mon_en = 1'b1;
    out_ready = 1'b1;

    send(11'h525);
    @(negedge clk);
    chk("clean_data", out_data, 8'hA5);
    chk("clean_corr", out_corr, 0);
    drain();

    send(11'h425);
    @(negedge clk);
    chk("err8_data", out_data, 8'hA5);
    chk("err8_syn", out_syn, 5);
    chk("err8_cnt", err_cnt, 1);
    drain();

    for (int b = 4; b <= 10; b++) begin
      cw = 11'h525 ^ (11'd1 << b);
      send(cw);
      @(negedge clk);
      chk("sweep_data", out_data, 8'hA5);
      chk("sweep_syn", out_syn, b - 3);
      chk("sweep_corr", out_corr, 1);
    end
    drain();

    send(11'h7FB);
    @(negedge clk);
    chk("nibble_data", out_data, 8'hFB);
    chk("nibble_corr", out_corr, 0);
    drain();

    out_ready = 1'b0;
    send(11'h000);
    send(11'h7FF);
    @(negedge clk);
    chk("bp_full_ready", in_ready, 0);
    chk("bp_hold_data", out_data, 8'h00);
    fork
      send(11'h525);
      begin repeat (3) @(posedge clk); #1 out_ready = 1'b1; end
    join
    drain();

    for (int i = 0; i < 10; i++) send(11'h525 ^ (11'd1 << (4 + i % 7)));
    drain();
    send(11'h425);
    drain();
    @(negedge clk);
    chk("sat_cnt", err_cnt, 4'hF);

    cnt_clr = 1'b1;
    send(11'h425);
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt", err_cnt, 0);
    drain();

    send(11'h425);
    out_ready = 1'b0;
    send(11'h7FF);
    @(negedge clk);
    chk("pre_rst_occ", out_valid & ~in_ready, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_cnt", err_cnt, 0);

    out_ready = 1'b1;
    send(11'h7FF);
    drain();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
